// File: rtl/touch_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module   : touch_pattern_generator
//  Purpose  : Seed-reproducible touch stimulus source. Emits a (valid, x, y)
//             stream organised as strokes separated by idle gaps. Each stroke
//             follows one of four motion modes (random walk, raster, bounce,
//             hold). Cycles are dropped pseudo-randomly using an internal
//             32-bit Galois LFSR, so the same seed always yields the same
//             sequence in simulation and on hardware.
//
//  Ports    : clk          - clock
//             rst          - asynchronous active-high reset
//             ena          - advance enable; low freezes all state
//             mode[1:0]    - 0 random walk, 1 raster, 2 bounce, 3 hold
//                            (sampled only when a stroke starts)
//             touch_valid  - registered touch valid
//             touch_x      - registered x coordinate
//             touch_y      - registered y coordinate
//             stroke_done  - one-cycle pulse with the last stroke output
//
//  Revision : 1.0  initial release
// ============================================================================
module touch_pattern_generator #(
    parameter int          DISPLAY_WIDTH  = 240,
    parameter int          DISPLAY_HEIGHT = 320,
    parameter int          MAX_STEP       = 8,
    parameter int          DROP_RATE      = 5,
    parameter int          STROKE_LEN     = 64,
    parameter int          GAP_CYCLES     = 16,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ena,
    input  logic [1:0]                         mode,
    output logic                               touch_valid,
    output logic [$clog2(DISPLAY_WIDTH)-1:0]   touch_x,
    output logic [$clog2(DISPLAY_HEIGHT)-1:0]  touch_y,
    output logic                               stroke_done
);

    localparam int XW      = $clog2(DISPLAY_WIDTH);
    localparam int YW      = $clog2(DISPLAY_HEIGHT);
    localparam int SW      = $clog2(MAX_STEP);
    localparam int CNT_MAX = (STROKE_LEN > GAP_CYCLES) ? STROKE_LEN : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    // Coordinate limits, one bit wider than the coordinate so that a sum
    // crossing the upper bound is still representable for the compare.
    localparam logic [XW:0]   X_MAX    = (XW+1)'(DISPLAY_WIDTH - 1);
    localparam logic [YW:0]   Y_MAX    = (YW+1)'(DISPLAY_HEIGHT - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(DISPLAY_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(DISPLAY_HEIGHT - 1);
    localparam logic [XW-1:0] X_MID    = XW'(DISPLAY_WIDTH / 2);
    localparam logic [YW-1:0] Y_MID    = YW'(DISPLAY_HEIGHT / 2);
    localparam logic [XW:0]   X_STEP   = (XW+1)'(MAX_STEP);
    localparam logic [YW:0]   Y_STEP   = (YW+1)'(MAX_STEP);

    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] STROKE_LAST = CW'(STROKE_LEN - 1);

    // DROP_RATE may be 128 (drop everything), hence the 8-bit threshold.
    localparam logic [7:0]  DROP_THR  = 8'(DROP_RATE);
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    // An all-zero Galois LFSR never leaves zero; substitute 1.
    localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

    localparam logic [1:0] MODE_WALK   = 2'd0;
    localparam logic [1:0] MODE_RASTER = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STROKE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,    state_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [31:0]     lfsr_q,     lfsr_d;
    logic [XW-1:0]   x_q,        x_d;
    logic [YW-1:0]   y_q,        y_d;
    logic            dirx_neg_q, dirx_neg_d;   // 1: bounce moving toward 0
    logic            diry_neg_q, diry_neg_d;
    logic [1:0]      mode_q,     mode_d;
    logic            valid_q,    valid_d;
    logic            done_q,     done_d;

    // ------------------------------------------------------------------
    // LFSR fields (all taken from the pre-advance value)
    // ------------------------------------------------------------------
    logic [31:0]   lfsr_next;
    logic          drop;
    logic          xneg;
    logic          yneg;
    logic [SW-1:0] dx;
    logic [SW-1:0] dy;

    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
    assign drop      = ({1'b0, lfsr_q[6:0]} < DROP_THR);
    assign xneg      = lfsr_q[7];
    assign yneg      = lfsr_q[8];
    assign dx        = lfsr_q[9 +: SW];
    assign dy        = lfsr_q[13 +: SW];

    // ------------------------------------------------------------------
    // Candidate positions, computed one bit wide so that the top bit of a
    // difference is the borrow (went below zero) and a sum can be compared
    // against the upper bound without wrapping.
    // ------------------------------------------------------------------
    logic [XW:0] x_ext, dx_ext, x_up_dx, x_dn_dx, x_up_st, x_dn_st;
    logic [YW:0] y_ext, dy_ext, y_up_dy, y_dn_dy, y_up_st, y_dn_st;

    assign x_ext   = {1'b0, x_q};
    assign y_ext   = {1'b0, y_q};
    assign dx_ext  = {{(XW+1-SW){1'b0}}, dx};
    assign dy_ext  = {{(YW+1-SW){1'b0}}, dy};
    assign x_up_dx = x_ext + dx_ext;
    assign x_dn_dx = x_ext - dx_ext;
    assign y_up_dy = y_ext + dy_ext;
    assign y_dn_dy = y_ext - dy_ext;
    assign x_up_st = x_ext + X_STEP;
    assign x_dn_st = x_ext - X_STEP;
    assign y_up_st = y_ext + Y_STEP;
    assign y_dn_st = y_ext - Y_STEP;

    // Random walk: clamp at the display edges, never wrap.
    logic [XW-1:0] walk_x;
    logic [YW-1:0] walk_y;

    assign walk_x = xneg ? (x_dn_dx[XW] ? '0 : x_dn_dx[XW-1:0])
                         : ((x_up_dx > X_MAX) ? X_LAST : x_up_dx[XW-1:0]);
    assign walk_y = yneg ? (y_dn_dy[YW] ? '0 : y_dn_dy[YW-1:0])
                         : ((y_up_dy > Y_MAX) ? Y_LAST : y_up_dy[YW-1:0]);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        x_d        = x_q;
        y_d        = y_q;
        dirx_neg_d = dirx_neg_q;
        diry_neg_d = diry_neg_q;
        mode_d     = mode_q;
        // Valid and done are cleared whenever the generator does not
        // advance, including while ena is low.
        valid_d    = 1'b0;
        done_d     = 1'b0;

        if (ena) begin
            lfsr_d = lfsr_next;

            case (state_q)
                ST_IDLE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        mode_d  = mode;
                        state_d = ST_STROKE;
                        if (mode == MODE_RASTER) begin
                            x_d = '0;
                            y_d = '0;
                        end else begin
                            x_d = X_MID;
                            y_d = Y_MID;
                        end
                        if (mode == MODE_BOUNCE) begin
                            dirx_neg_d = 1'b0;
                            diry_neg_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                ST_STROKE: begin
                    valid_d = !drop;

                    // Dropped cycles leave the position untouched.
                    if (!drop) begin
                        case (mode_q)
                            MODE_WALK: begin
                                x_d = walk_x;
                                y_d = walk_y;
                            end

                            MODE_RASTER: begin
                                if (x_up_st > X_MAX) begin
                                    x_d = '0;
                                    y_d = (y_up_st > Y_MAX) ? '0 : y_up_st[YW-1:0];
                                end else begin
                                    x_d = x_up_st[XW-1:0];
                                end
                            end

                            MODE_BOUNCE: begin
                                if (!dirx_neg_q) begin
                                    if (x_up_st > X_MAX) begin
                                        x_d        = X_LAST;
                                        dirx_neg_d = 1'b1;
                                    end else begin
                                        x_d = x_up_st[XW-1:0];
                                    end
                                end else begin
                                    if (x_dn_st[XW]) begin
                                        x_d        = '0;
                                        dirx_neg_d = 1'b0;
                                    end else begin
                                        x_d = x_dn_st[XW-1:0];
                                    end
                                end

                                if (!diry_neg_q) begin
                                    if (y_up_st > Y_MAX) begin
                                        y_d        = Y_LAST;
                                        diry_neg_d = 1'b1;
                                    end else begin
                                        y_d = y_up_st[YW-1:0];
                                    end
                                end else begin
                                    if (y_dn_st[YW]) begin
                                        y_d        = '0;
                                        diry_neg_d = 1'b0;
                                    end else begin
                                        y_d = y_dn_st[YW-1:0];
                                    end
                                end
                            end

                            default: begin
                                // HOLD: position stays put, only valid toggles.
                            end
                        endcase
                    end

                    if (cnt_q == STROKE_LAST) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lfsr_q     <= SEED_EFF;
            x_q        <= X_MID;
            y_q        <= Y_MID;
            dirx_neg_q <= 1'b0;
            diry_neg_q <= 1'b0;
            mode_q     <= 2'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dirx_neg_q <= dirx_neg_d;
            diry_neg_q <= diry_neg_d;
            mode_q     <= mode_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign touch_valid = valid_q;
    assign touch_x     = x_q;
    assign touch_y     = y_q;
    assign stroke_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_pattern_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_touch_pattern_generator
//  Purpose  : Self-checking bench for touch_pattern_generator. Three instances
//             share the same stimulus: no dropouts, all dropped, and the
//             default drop rate. An independent reference model pushes the
//             expected outputs of every instance into a scoreboard queue each
//             time stimulus is driven; they are popped and compared after the
//             clock edge. Hand-computed tables cover raster and bounce paths.
//  Revision : 1.0  initial release
// ============================================================================
module tb_touch_pattern_generator;

    localparam int          W     = 240;
    localparam int          H     = 320;
    localparam int          STEP  = 8;
    localparam int          SLEN  = 64;
    localparam int          GAP   = 16;
    localparam logic [31:0] POLY  = 32'h8020_0003;
    localparam logic [31:0] SEED  = 32'hACE1_2468;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       ena  = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       v_a, v_b, v_c, d_a, d_b, d_c;
    logic [7:0] x_a, x_b, x_c;
    logic [8:0] y_a, y_b, y_c;

    always #5 clk = ~clk;

    touch_pattern_generator #(.DROP_RATE(0)) u_a (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .touch_valid(v_a), .touch_x(x_a), .touch_y(y_a), .stroke_done(d_a));

    touch_pattern_generator #(.DROP_RATE(128)) u_b (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .touch_valid(v_b), .touch_x(x_b), .touch_y(y_b), .stroke_done(d_b));

    touch_pattern_generator u_c (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .touch_valid(v_c), .touch_x(x_c), .touch_y(y_c), .stroke_done(d_c));

    int n_vec = 0;
    int n_err = 0;

    // ---------------------------------------------------------------
    // Reference model + scoreboard
    // ---------------------------------------------------------------
    typedef struct {
        logic v;
        int   x;
        int   y;
        logic d;
    } exp_t;

    exp_t sb_q[$];

    int          drop_rate [3] = '{0, 128, 5};
    logic [31:0] m_lfsr    [3];
    bit          m_stroke  [3];
    int          m_cnt     [3];
    int          m_x       [3];
    int          m_y       [3];
    int          m_sx      [3];
    int          m_sy      [3];
    logic [1:0]  m_mode    [3];

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lfsr[i]   = SEED;
            m_stroke[i] = 1'b0;
            m_cnt[i]    = 0;
            m_x[i]      = W / 2;
            m_y[i]      = H / 2;
            m_sx[i]     = 1;
            m_sy[i]     = 1;
            m_mode[i]   = 2'd0;
        end
    endtask

    task automatic model_step(input logic e, input logic [1:0] md);
        for (int i = 0; i < 3; i++) begin
            exp_t        ex;
            logic [31:0] l;
            bit          drp;
            int          dx, dy, nx, ny;
            ex.v = 1'b0;
            ex.d = 1'b0;
            if (e) begin
                l   = m_lfsr[i];
                drp = (int'(l[6:0]) < drop_rate[i]);
                dx  = int'(l[11:9]);
                dy  = int'(l[15:13]);
                if (!m_stroke[i]) begin
                    if (m_cnt[i] == GAP - 1) begin
                        m_cnt[i]    = 0;
                        m_mode[i]   = md;
                        m_stroke[i] = 1'b1;
                        m_x[i]      = (md == 2'd1) ? 0 : W / 2;
                        m_y[i]      = (md == 2'd1) ? 0 : H / 2;
                        if (md == 2'd2) begin
                            m_sx[i] = 1;
                            m_sy[i] = 1;
                        end
                    end else begin
                        m_cnt[i]++;
                    end
                end else begin
                    ex.v = !drp;
                    if (!drp) begin
                        case (m_mode[i])
                            2'd0: begin
                                m_x[i] = clampi(l[7] ? m_x[i] - dx : m_x[i] + dx, 0, W - 1);
                                m_y[i] = clampi(l[8] ? m_y[i] - dy : m_y[i] + dy, 0, H - 1);
                            end
                            2'd1: begin
                                if (m_x[i] + STEP > W - 1) begin
                                    m_x[i] = 0;
                                    m_y[i] = (m_y[i] + STEP > H - 1) ? 0 : m_y[i] + STEP;
                                end else begin
                                    m_x[i] = m_x[i] + STEP;
                                end
                            end
                            2'd2: begin
                                nx = m_x[i] + STEP * m_sx[i];
                                if (nx > W - 1) begin nx = W - 1; m_sx[i] = -1; end
                                else if (nx < 0) begin nx = 0; m_sx[i] = 1; end
                                ny = m_y[i] + STEP * m_sy[i];
                                if (ny > H - 1) begin ny = H - 1; m_sy[i] = -1; end
                                else if (ny < 0) begin ny = 0; m_sy[i] = 1; end
                                m_x[i] = nx;
                                m_y[i] = ny;
                            end
                            default: ;
                        endcase
                    end
                    if (m_cnt[i] == SLEN - 1) begin
                        ex.d        = 1'b1;
                        m_cnt[i]    = 0;
                        m_stroke[i] = 1'b0;
                    end else begin
                        m_cnt[i]++;
                    end
                end
                m_lfsr[i] = (l >> 1) ^ (l[0] ? POLY : 32'd0);
            end
            ex.x = m_x[i];
            ex.y = m_y[i];
            sb_q.push_back(ex);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            exp_t ex;
            logic gv, gd;
            int   gx, gy;
            ex = sb_q.pop_front();
            case (i)
                0:       begin gv = v_a; gx = int'(x_a); gy = int'(y_a); gd = d_a; end
                1:       begin gv = v_b; gx = int'(x_b); gy = int'(y_b); gd = d_b; end
                default: begin gv = v_c; gx = int'(x_c); gy = int'(y_c); gd = d_c; end
            endcase
            n_vec++;
            if (gv !== ex.v || gd !== ex.d || gx != ex.x || gy != ex.y) begin
                n_err++;
                $display("FAIL model[%0d] t=%0t: got v=%b x=%0d y=%0d done=%b, want v=%b x=%0d y=%0d done=%b",
                         i, $time, gv, gx, gy, gd, ex.v, ex.x, ex.y, ex.d);
            end
        end
    endtask

    task automatic cmp(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // One clock: drive inputs, predict, then compare after the edge.
    task automatic cyc(input logic e, input logic [1:0] m);
        ena  = e;
        mode = m;
        model_step(e, m);
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Reset asserted between edges; outputs must already show reset values.
    task automatic do_reset(input string nm);
        rst = 1'b1;
        #1;
        cmp({nm, ".a.valid"}, int'(v_a), 0);
        cmp({nm, ".a.x"},     int'(x_a), W / 2);
        cmp({nm, ".a.y"},     int'(y_a), H / 2);
        cmp({nm, ".c.done"},  int'(d_c), 0);
        cmp({nm, ".c.x"},     int'(x_c), W / 2);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------
    // Table-driven vectors (instance A, no dropouts)
    // ---------------------------------------------------------------
    typedef struct {
        logic       e;
        logic [1:0] m;
        int         n;    // cycles to apply before comparing
        logic       v;
        int         x;
        int         y;
        logic       d;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic e, input logic [1:0] m, input int n,
                       input logic v, input int x, input int y, input logic d);
        vec_t t;
        t.e = e; t.m = m; t.n = n; t.v = v; t.x = x; t.y = y; t.d = d;
        tab.push_back(t);
    endtask

    task automatic run_table(input string nm);
        foreach (tab[k]) begin
            repeat (tab[k].n) cyc(tab[k].e, tab[k].m);
            cmp($sformatf("%s[%0d].valid", nm, k), int'(v_a), int'(tab[k].v));
            cmp($sformatf("%s[%0d].x", nm, k),     int'(x_a), tab[k].x);
            cmp($sformatf("%s[%0d].y", nm, k),     int'(y_a), tab[k].y);
            cmp($sformatf("%s[%0d].done", nm, k),  int'(d_a), int'(tab[k].d));
        end
        tab.delete();
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_valid, b_moved, b_done, bad;

        #2;
        do_reset("reset0");
        cmp("reset.lfsr", int'(u_c.lfsr_q), int'(SEED));

        // Enable low: everything frozen.
        repeat (100) cyc(1'b0, 2'd0);
        cmp("ena_low.lfsr", int'(u_c.lfsr_q), int'(SEED));
        cmp("ena_low.x", int'(x_c), 120);
        cmp("ena_low.y", int'(y_c), 160);

        // Raster, no dropouts.
        add(1, 2'd1, 15, 0, 120, 160, 0);
        add(1, 2'd1, 1,  0, 0,   0,   0);
        add(1, 2'd1, 1,  1, 8,   0,   0);
        add(1, 2'd1, 28, 1, 232, 0,   0);
        add(1, 2'd1, 1,  1, 0,   8,   0);
        add(1, 2'd1, 34, 1, 32,  16,  1);
        add(1, 2'd1, 1,  0, 32,  16,  0);
        add(1, 2'd1, 15, 0, 0,   0,   0);
        add(1, 2'd1, 1,  1, 8,   0,   0);
        add(0, 2'd1, 1,  0, 8,   0,   0);
        add(1, 2'd1, 1,  1, 16,  0,   0);
        run_table("raster");

        // Bounce, no dropouts.
        do_reset("reset1");
        add(1, 2'd2, 16, 0, 120, 160, 0);
        add(1, 2'd2, 1,  1, 128, 168, 0);
        add(1, 2'd2, 13, 1, 232, 272, 0);
        add(1, 2'd2, 1,  1, 239, 280, 0);
        add(1, 2'd2, 1,  1, 231, 288, 0);
        add(1, 2'd2, 4,  1, 199, 319, 0);
        add(1, 2'd2, 1,  1, 191, 311, 0);
        add(1, 2'd2, 23, 1, 7,   127, 0);
        add(1, 2'd2, 1,  1, 0,   119, 0);
        add(1, 2'd2, 15, 1, 120, 0,   0);
        add(1, 2'd2, 4,  1, 152, 32,  1);
        add(1, 2'd2, 16, 0, 120, 160, 0);
        add(1, 2'd2, 1,  1, 128, 168, 0);
        run_table("bounce");

        // All cycles dropped on instance B, random walk.
        do_reset("reset2");
        b_valid = 0; b_moved = 0; b_done = 0;
        for (int k = 0; k < 160; k++) begin
            cyc(1'b1, 2'd0);
            if (v_b) b_valid++;
            if (x_b != 8'd120 || y_b != 9'd160) b_moved++;
            if (d_b) b_done++;
        end
        cmp("drop_all.valid_count", b_valid, 0);
        cmp("drop_all.moved_count", b_moved, 0);
        cmp("drop_all.done_count",  b_done,  2);

        // Mode change mid-stroke takes effect only at the next stroke.
        do_reset("reset3");
        repeat (26) cyc(1'b1, 2'd0);
        repeat (70) cyc(1'b1, 2'd1);
        cmp("mode_change.start_valid", int'(v_a), 0);
        cmp("mode_change.start_x",     int'(x_a), 0);
        cmp("mode_change.start_y",     int'(y_a), 0);
        cyc(1'b1, 2'd1);
        cmp("mode_change.first_x",     int'(x_a), 8);
        cmp("mode_change.first_valid", int'(v_a), 1);

        // Abort mid-stroke, then replay from the seed.
        repeat (30) cyc(1'b1, 2'd1);
        do_reset("midstroke");
        repeat (160) cyc(1'b1, 2'd0);

        // Random enable and mode; the model tracks every cycle.
        bad = 0;
        for (int k = 0; k < 10000; k++) begin
            cyc(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)));
            if (x_a > 8'd239 || x_b > 8'd239 || x_c > 8'd239) bad++;
            if (y_a > 9'd319 || y_b > 9'd319 || y_c > 9'd319) bad++;
        end
        cmp("random.range_violations", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
